// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole blocks: FSM state encoding,
// LFSR polynomial/seed and the level width.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  localparam int          LVL_W          = 3;
  localparam int          TMR_W          = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1, o_tick high while at TICK_DIV-1.
// i_clr restarts the count so a freshly loaded timer sees a full first tick.
module ms_tick #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (i_clr || r_cnt == LAST) r_cnt <= '0;
    else                            r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/mole_scheduler.sv
// Mole sequencer: hidden gap, mole up on a pseudo-random hole, cooldown; judges
// button presses and raises the level every HITS_PER_LEVEL correct hits.
module mole_scheduler import whack_pkg::*; #(
  parameter int          N_HOLES        = 4,
  parameter int          TICK_DIV       = 100000,
  parameter int          UP_MS_INIT     = 1000,
  parameter int          UP_MS_STEP     = 100,
  parameter int          UP_MS_MIN      = 300,
  parameter int          GAP_MS_MIN     = 200,
  parameter int          COOL_MS        = 150,
  parameter int          HITS_PER_LEVEL = 4,
  parameter int          LEVEL_MAX      = 7,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       game_active,
  // hit_valid is a single-cycle pulse with no backpressure; hit_idx is
  // meaningful only in that cycle.
  input  logic                       hit_valid,
  input  logic [$clog2(N_HOLES)-1:0] hit_idx,
  output logic [N_HOLES-1:0]         mole_mask,
  output logic                       hit,
  output logic                       miss,
  output logic [LVL_W-1:0]           level,
  output logic                       busy,
  output state_e                     dbg_state
);

  localparam int HB = $clog2(N_HOLES);

  state_e             r_state, w_state_nxt;
  logic [15:0]        r_lfsr;
  logic [TMR_W-1:0]   r_timer, w_load_val, w_up_ms, w_gap_ms;
  logic [31:0]        w_up_prod;
  logic [HB-1:0]      r_hole, w_hole_raw, w_hole_pick;
  logic               r_hole_vld;
  logic [N_HOLES-1:0] r_mask;
  logic               r_hit, r_miss, w_hit_nxt, w_miss_nxt;
  logic [LVL_W-1:0]   r_level;
  logic [7:0]         r_hit_cnt;
  logic               w_tick, w_tick_clr, w_expire, w_load, w_pick, w_correct;

  ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tick_clr),
    .o_tick(w_tick)
  );

  assign w_tick_clr  = (r_state == ST_IDLE) || (w_state_nxt != r_state);
  assign w_expire    = w_tick && (r_timer <= TMR_W'(1));
  assign w_gap_ms    = TMR_W'(GAP_MS_MIN) + TMR_W'(r_lfsr[7:0]);
  assign w_hole_raw  = r_lfsr[HB-1:0];
  assign w_hole_pick = (r_hole_vld && w_hole_raw == r_hole) ? w_hole_raw + HB'(1) : w_hole_raw;

  // Compare before subtracting so a high level floors at UP_MS_MIN instead of wrapping.
  always_comb begin
    w_up_prod = 32'(r_level) * 32'(UP_MS_STEP);
    if (w_up_prod >= 32'(UP_MS_INIT) || (32'(UP_MS_INIT) - w_up_prod) < 32'(UP_MS_MIN))
      w_up_ms = TMR_W'(UP_MS_MIN);
    else
      w_up_ms = TMR_W'(32'(UP_MS_INIT) - w_up_prod);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_gap_ms;
    w_pick      = 1'b0;
    w_correct   = 1'b0;
    if (!game_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
        end
        ST_GAP: begin
          w_miss_nxt = hit_valid;
          if (w_expire) begin
            w_state_nxt = ST_UP;
            w_load      = 1'b1;
            w_load_val  = w_up_ms;
            w_pick      = 1'b1;
          end
        end
        ST_UP: begin
          if (hit_valid && hit_idx == r_hole) begin
            w_hit_nxt   = 1'b1;
            w_correct   = 1'b1;
            w_state_nxt = ST_COOL;
            w_load      = 1'b1;
            w_load_val  = TMR_W'(COOL_MS);
          end else begin
            w_miss_nxt = hit_valid || w_expire;
            if (w_expire) begin
              w_state_nxt = ST_COOL;
              w_load      = 1'b1;
              w_load_val  = TMR_W'(COOL_MS);
            end
          end
        end
        ST_COOL: begin
          w_miss_nxt = hit_valid;
          if (w_expire) begin
            w_state_nxt = ST_GAP;
            w_load      = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= lfsr_step(r_lfsr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_timer <= '0;
    else if (w_load)                   r_timer <= w_load_val;
    else if (w_tick && r_timer != '0)  r_timer <= r_timer - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask     <= '0;
      r_hole     <= '0;
      r_hole_vld <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_hit  <= w_hit_nxt;
      r_miss <= w_miss_nxt;
      if (w_pick) begin
        r_hole     <= w_hole_pick;
        r_hole_vld <= 1'b1;
        r_mask     <= N_HOLES'(1) << w_hole_pick;
      end else if (w_state_nxt != ST_UP) begin
        r_mask <= '0;
      end
    end
  end

  // Level survives a game stop so the final score can be shown; cleared on restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level   <= '0;
      r_hit_cnt <= '0;
    end else if (r_state == ST_IDLE && game_active) begin
      r_level   <= '0;
      r_hit_cnt <= '0;
    end else if (w_correct) begin
      if (r_hit_cnt == 8'(HITS_PER_LEVEL - 1)) begin
        r_hit_cnt <= '0;
        if (r_level < LVL_W'(LEVEL_MAX)) r_level <= r_level + 1'b1;
      end else begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
    end
  end

  assign mole_mask = r_mask;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign level     = r_level;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
